// File: rtl/narb_rr_sched.sv
// narb_rr_sched: round-robin NoC arbiter with packet locking and credit-based downstream flow control.
// Optional feature macro: NARB_BCONT_PRIO_EN gives requester 0 (bcont) absolute priority in IDLE arbitration.
module narb_rr_sched #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REQ      = 4,
  parameter int CREDITS      = 4,
  parameter int LOG2_CREDITS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          credit_i,
  output logic [DATA_WIDTH-1:0]         noc_o,
  output logic                          noc_valid_o,
  output logic                          noc_last_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [LOG2_CREDITS:0]         credit_cnt_o,
  output logic                          ovf_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = LOG2_CREDITS + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [PTR_W-1:0]   pick_idx, cand;
  logic               pick_found;
  logic               bcont_win;
  logic               credit_avail;
  logic               beat_acc;
  logic               beat_last;
  logic [DATA_WIDTH-1:0] beat_data;

`ifdef NARB_BCONT_PRIO_EN
  assign bcont_win = req_valid_i[0];
`else
  assign bcont_win = 1'b0;
`endif

  // Valid/ready: a beat moves on a rising edge where req_valid_i[i] && req_ready_o[i];
  // ready depends only on grant and credits, never on valid.
  assign credit_avail = (credit_cnt_o != '0);
  assign req_ready_o  = (state_q == BUSY && credit_avail) ? grant_o : '0;
  assign beat_acc     = |(req_valid_i & req_ready_o);
  assign beat_last    = req_last_i[owner_q];
  assign beat_data    = req_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_o;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (bcont_win) begin
          state_d    = BUSY;
          owner_d    = '0;
          grant_d[0] = 1'b1;
        end else if (pick_found) begin
          state_d           = BUSY;
          owner_d           = pick_idx;
          grant_d[pick_idx] = 1'b1;
          rr_ptr_d          = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
        end
      end
      BUSY: begin
        if (beat_acc && beat_last) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_o  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_o  <= grant_d;
    end
  end

  // Output flit register and credit bookkeeping; an extra credit at full count is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      noc_valid_o  <= 1'b0;
      noc_o        <= '0;
      noc_last_o   <= 1'b0;
      credit_cnt_o <= CNT_FULL;
      ovf_o        <= 1'b0;
    end else begin
      noc_valid_o <= beat_acc;
      if (beat_acc) begin
        noc_o      <= beat_data;
        noc_last_o <= beat_last;
      end
      if (beat_acc && !credit_i) begin
        credit_cnt_o <= credit_cnt_o - 1'b1;
      end else if (!beat_acc && credit_i) begin
        if (credit_cnt_o == CNT_FULL) begin
          ovf_o <= 1'b1;
        end else begin
          credit_cnt_o <= credit_cnt_o + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_narb_rr_sched.sv
// tb_narb_rr_sched: directed and randomized checks of narb_rr_sched against a packet-level model.
// Honors NARB_BCONT_PRIO_EN the same way the design does.
module tb_narb_rr_sched;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int CR = 4;
  localparam int LC = 2;
  localparam int PW = 2;

  typedef logic [DW:0] flit_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready_o;
  logic            credit_i;
  logic [DW-1:0]   noc_o;
  logic            noc_valid_o;
  logic            noc_last_o;
  logic [N-1:0]    grant_o;
  logic [LC:0]     credit_cnt_o;
  logic            ovf_o;

  always #5 clk = ~clk;

  narb_rr_sched #(
    .DATA_WIDTH(DW), .NUM_REQ(N), .CREDITS(CR), .LOG2_CREDITS(LC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
    .req_ready_o(req_ready_o), .credit_i(credit_i),
    .noc_o(noc_o), .noc_valid_o(noc_valid_o), .noc_last_o(noc_last_o),
    .grant_o(grant_o), .credit_cnt_o(credit_cnt_o), .ovf_o(ovf_o)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic         chk_en   = 1'b0;
  flit_t        src_q[N][$];
  logic [N-1:0] hold;
  flit_t        out_log[$];
  logic [N-1:0] g_log[$];
  logic [N-1:0] prev_g = '0;
  int           m_glog[$];

  // Packet-level model: owner index, pointer, credit count as plain integers.
  logic          m_busy = 1'b0;
  logic [PW-1:0] m_owner = '0;
  logic [PW-1:0] m_ptr = '0;
  int            m_cred = CR;
  logic          m_ovf = 1'b0;
  logic          m_nv = 1'b0;
  logic [DW-1:0] m_noc = '0;
  logic          m_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] out_at(input int k);
    return (out_log.size() > k) ? 32'(out_log[k]) : 32'hdead_beef;
  endfunction

  function automatic logic [31:0] g_at(input int k);
    return (g_log.size() > k) ? 32'(g_log[k]) : 32'hdead_beef;
  endfunction

  function automatic logic [31:0] mg_at(input int k);
    return (m_glog.size() > k) ? 32'(m_glog[k]) : 32'hdead_beef;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] vsh, lsh;
    int pick;
    int c;
    logic acc;
    if (!rst) begin
      m_busy = 1'b0; m_owner = '0; m_ptr = '0; m_cred = CR; m_ovf = 1'b0;
      m_nv = 1'b0; m_noc = '0; m_last = 1'b0;
    end else begin
      vsh = req_valid >> m_owner;
      lsh = req_last >> m_owner;
      acc = m_busy && (m_cred > 0) && vsh[0];
      m_nv = acc;
      if (acc) begin
        m_noc  = req_data[int'(m_owner)*DW +: DW];
        m_last = lsh[0];
      end
      if (acc && !credit_i) m_cred = m_cred - 1;
      else if (!acc && credit_i) begin
        if (m_cred == CR) m_ovf = 1'b1;
        else m_cred = m_cred + 1;
      end
      if (!m_busy) begin
        pick = -1;
`ifdef NARB_BCONT_PRIO_EN
        if (req_valid[0]) pick = 0;
`endif
        if (pick < 0) begin
          for (int k = 0; k < N; k++) begin
            c = (int'(m_ptr) + k) % N;
            if (pick < 0 && ((req_valid >> c) & 1) != 0) begin
              pick  = c;
              m_ptr = PW'((c + 1) % N);
            end
          end
        end
        if (pick >= 0) begin
          m_busy  = 1'b1;
          m_owner = PW'(pick);
          m_glog.push_back(pick);
        end
      end else if (acc && lsh[0]) begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg, er;
    if (chk_en) begin
      eg = m_busy ? (N'(1) << m_owner) : '0;
      er = (m_busy && m_cred > 0) ? eg : '0;
      check("grant_o", 32'(grant_o), 32'(eg));
      check("req_ready_o", 32'(req_ready_o), 32'(er));
      check("noc_valid_o", 32'(noc_valid_o), 32'(m_nv));
      check("noc_o", 32'(noc_o), 32'(m_noc));
      check("noc_last_o", 32'(noc_last_o), 32'(m_last));
      check("credit_cnt_o", 32'(credit_cnt_o), 32'(m_cred));
      check("ovf_o", 32'(ovf_o), 32'(m_ovf));
    end
    if (noc_valid_o === 1'b1) out_log.push_back({noc_last_o, noc_o});
    if (grant_o != '0 && prev_g == '0) g_log.push_back(grant_o);
    prev_g = grant_o;
  end

  task automatic apply_src();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = src_q[i][0][DW];
        req_data[i*DW +: DW]  = src_q[i][0][DW-1:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'($urandom_range(0, 1));
        req_data[i*DW +: DW]  = DW'($urandom);
      end
    end
  endtask

  task automatic cycle(input logic cr);
    logic [N-1:0] fire;
    credit_i = cr;
    @(negedge clk);
    fire = req_valid & req_ready_o;
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++)
      if (fire[i] && rst && src_q[i].size() > 0) void'(src_q[i].pop_front());
    apply_src();
  endtask

  task automatic clear_logs();
    out_log.delete();
    g_log.delete();
    m_glog.delete();
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    hold = '0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    apply_src();
    cycle(1'b0);
    cycle(1'b0);
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, 32'(grant_o), 32'h0);
    check({tag, "_ready"}, 32'(req_ready_o), 32'h0);
    check({tag, "_nvalid"}, 32'(noc_valid_o), 32'h0);
    check({tag, "_noc"}, 32'(noc_o), 32'h0);
    check({tag, "_nlast"}, 32'(noc_last_o), 32'h0);
    check({tag, "_credit"}, 32'(credit_cnt_o), 32'd4);
    check({tag, "_ovf"}, 32'(ovf_o), 32'h0);
  endtask

  logic [N-1:0] exp_a, exp_b;
  int len;

  initial begin
`ifdef NARB_BCONT_PRIO_EN
    exp_a = 4'b0001;
    exp_b = 4'b0001;
`else
    exp_a = 4'b0010;
    exp_b = 4'b0100;
`endif
    rst = 1'b0; credit_i = 1'b0; hold = '0;
    req_valid = '0; req_last = '0; req_data = '0;
    apply_src();
    cycle(1'b0);
    chk_en = 1'b1;
    check_reset_vals("reset");
    do_reset();

    // Two one-flit packets from requesters 1 and 2, no credits returned.
    src_q[1].push_back({1'b1, 16'h1111});
    src_q[2].push_back({1'b1, 16'h2222});
    apply_src();
    repeat (6) cycle(1'b0);
    check("s1_flit0", out_at(0), {15'h0, 1'b1, 16'h1111});
    check("s1_flit1", out_at(1), {15'h0, 1'b1, 16'h2222});
    check("s1_grant0", g_at(0), 32'b0010);
    check("s1_grant1", g_at(1), 32'b0100);
    check("s1_credit", 32'(credit_cnt_o), 32'd2);
    check("s1_model_cred", 32'(m_cred), 32'd2);
    check("s1_model_g1", mg_at(1), 32'd2);

    // All four requesters busy, credit returned every cycle.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) src_q[i].push_back({1'b1, DW'(16'h0100 * i + k)});
    apply_src();
    repeat (20) cycle(1'b1);
    check("s2_g0", g_at(0), 32'b0001);
    check("s2_g1", g_at(1), 32'b0010);
    check("s2_g2", g_at(2), 32'b0100);
    check("s2_g3", g_at(3), 32'b1000);
    check("s2_g4", g_at(4), 32'b0001);
    check("s2_model_g3", mg_at(3), 32'd3);
    check("s2_nflits", 32'(out_log.size()), 32'd8);

    // Requester 3 holds a 3-flit packet while requester 1 waits.
    do_reset();
    src_q[3].push_back({1'b0, 16'h3001});
    src_q[3].push_back({1'b0, 16'h3002});
    src_q[3].push_back({1'b1, 16'h3003});
    apply_src();
    cycle(1'b0);
    src_q[1].push_back({1'b1, 16'h1001});
    apply_src();
    repeat (8) cycle(1'b0);
    check("s3_f0", out_at(0), {15'h0, 1'b0, 16'h3001});
    check("s3_f1", out_at(1), {15'h0, 1'b0, 16'h3002});
    check("s3_f2", out_at(2), {15'h0, 1'b1, 16'h3003});
    check("s3_f3", out_at(3), {15'h0, 1'b1, 16'h1001});
    check("s3_g0", g_at(0), 32'b1000);
    check("s3_g1", g_at(1), 32'b0010);

    // Credit starvation on a 6-flit packet from requester 2.
    do_reset();
    for (int k = 0; k < 6; k++) src_q[2].push_back({(k == 5), DW'(16'h2000 + k)});
    apply_src();
    repeat (10) cycle(1'b0);
    check("s4_stall_n", 32'(out_log.size()), 32'd4);
    check("s4_stall_ready", 32'(req_ready_o), 32'h0);
    check("s4_stall_grant", 32'(grant_o), 32'b0100);
    check("s4_stall_credit", 32'(credit_cnt_o), 32'd0);
    cycle(1'b1);
    cycle(1'b1);
    repeat (4) cycle(1'b0);
    check("s4_done_n", 32'(out_log.size()), 32'd6);
    check("s4_tail", out_at(5), {15'h0, 1'b1, 16'h2005});
    check("s4_done_grant", 32'(grant_o), 32'h0);

    // Overflow at full count, then reset in the middle of a packet.
    do_reset();
    cycle(1'b1);
    check("s5_ovf", 32'(ovf_o), 32'h1);
    check("s5_ovf_cnt", 32'(credit_cnt_o), 32'd4);
    for (int k = 0; k < 4; k++) src_q[2].push_back({(k == 3), DW'(16'h2a00 + k)});
    apply_src();
    repeat (3) cycle(1'b0);
    rst = 1'b0;
    cycle(1'b0);
    check_reset_vals("midrst");
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    clear_logs();
    src_q[1].push_back({1'b1, 16'h1b1b});
    src_q[3].push_back({1'b1, 16'h3b3b});
    apply_src();
    repeat (2) cycle(1'b0);
    check("s5_restart_g", g_at(0), 32'b0010);
    check("s5_restart_model", mg_at(0), 32'd1);

    // bcont priority: pointer at 1 with requesters 0 and 1 valid.
    do_reset();
    src_q[0].push_back({1'b1, 16'h0a0a});
    apply_src();
    repeat (3) cycle(1'b0);
    clear_logs();
    src_q[0].push_back({1'b1, 16'h0a0b});
    src_q[1].push_back({1'b1, 16'h1a1b});
    apply_src();
    repeat (5) cycle(1'b0);
    check("s6_first", g_at(0), 32'(exp_a));
    check("s6_second", g_at(1), 32'(exp_a ^ 4'b0011));

    // bcont priority: pointer at 2 with requesters 0 and 2 valid.
    do_reset();
    src_q[1].push_back({1'b1, 16'h1c1c});
    apply_src();
    repeat (3) cycle(1'b0);
    clear_logs();
    src_q[0].push_back({1'b1, 16'h0c0c});
    src_q[2].push_back({1'b1, 16'h2c2c});
    apply_src();
    repeat (5) cycle(1'b0);
    check("s6b_first", g_at(0), 32'(exp_b));

    // Randomized traffic with valid gaps and random credit returns.
    do_reset();
    for (int t = 0; t < 2000; t++) begin
      if (t == 1000) do_reset();
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) src_q[i].push_back({(k == len - 1), DW'($urandom)});
        end
        hold[i] = ($urandom_range(0, 4) == 0);
      end
      apply_src();
      cycle($urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
